// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: area-minimal ALU that evaluates a WIDTH-bit MIPS-style
// operation one bit per clock, LSB first, through a single 1-bit ALU slice.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   in_valid/ready   operand handshake; in_ready is high only while idle
//   src_a, src_b     operands, latched on accept
//   alu_ctrl         {Ainvert, Binvert, Operation[1:0]}
//   out_valid/ready  result handshake; out_valid held until accepted
//   result           ALU result (holds after hand-off until the next accept)
//   zero             result == 0, decoded from the result register
//   overflow         signed overflow, ADD/SUB (Operation == 10) only
//
// Optional feature macro: BIT_SERIAL_ALU_FAST_LOGIC_EN
//   When defined, Operation 00/01 (AND/OR/NOR) is evaluated full-width in a
//   single cycle instead of walking the serial slice.
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE,
        S_FAST
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               set_q, set_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // 1-bit slice signals for the bit currently selected by cnt_q
    logic ai, bi, sum, cout, ovf_v, bit_v;

`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
    logic [WIDTH-1:0] av_full, bv_full;
`endif

    // Next-state, slice evaluation and register updates
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        set_d       = set_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        ai    = a_q[cnt_q] ^ ctrl_q[3];
        bi    = b_q[cnt_q] ^ ctrl_q[2];
        sum   = ai ^ bi ^ carry_q;
        cout  = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        ovf_v = carry_q ^ cout;

        case (ctrl_q[1:0])
            2'b00:   bit_v = ai & bi;
            2'b01:   bit_v = ai | bi;
            2'b10:   bit_v = sum;
            default: bit_v = 1'b0;   // SLT: bit 0 patched in S_FIX
        endcase

`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
        av_full = a_q ^ {WIDTH{ctrl_q[3]}};
        bv_full = b_q ^ {WIDTH{ctrl_q[2]}};
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = src_a;
                    b_d        = src_b;
                    ctrl_d     = alu_ctrl;
                    carry_d    = alu_ctrl[2];   // Binvert doubles as carry-in for SUB/SLT
                    cnt_d      = '0;
                    result_d   = '0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b0;
`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
                    state_d    = alu_ctrl[1] ? S_RUN : S_FAST;
`else
                    state_d    = S_RUN;
`endif
                end
            end

            S_RUN: begin
                result_d[cnt_q] = bit_v;
                carry_d         = cout;
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    // sum^ovf is the true sign, so SLT stays correct on overflow
                    set_d = sum ^ ovf_v;
                    ovf_d = (ctrl_q[1:0] == 2'b10) ? ovf_v : 1'b0;
                    if (ctrl_q[1:0] == 2'b11) begin
                        state_d = S_FIX;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FIX: begin
                result_d[0] = set_q;
                state_d     = S_DONE;
                out_valid_d = 1'b1;
            end

`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
            S_FAST: begin
                result_d    = ctrl_q[0] ? (av_full | bv_full) : (av_full & bv_full);
                ovf_d       = 1'b0;
                state_d     = S_DONE;
                out_valid_d = 1'b1;
            end
`endif

            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            set_q       <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            set_q       <= set_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Testbench for bit_serial_alu_seq (WIDTH=32): directed and random operations
// checked every cycle against an arithmetic reference model.
module tb_bit_serial_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    bit_serial_alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
    localparam int LOGIC_LAT = 2;
`else
    localparam int LOGIC_LAT = 33;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU: plain two's-complement arithmetic on the (optionally inverted) operands
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                    output logic [31:0] r, output logic o);
        logic [31:0] av, bv;
        longint      s;
        av = c[3] ? ~a : a;
        bv = c[2] ? ~b : b;
        s  = longint'($signed(av)) + longint'($signed(bv)) + longint'(c[2]);
        case (c[1:0])
            2'b00:   r = av & bv;
            2'b01:   r = av | bv;
            2'b10:   r = 32'(s);
            default: r = (s < 0) ? 32'd1 : 32'd0;
        endcase
        o = (c[1:0] == 2'b10) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    endfunction

    function automatic int lat_of(input logic [3:0] c);
`ifdef BIT_SERIAL_ALU_FAST_LOGIC_EN
        if (!c[1]) return 2;
`endif
        return (c[1:0] == 2'b11) ? 34 : 33;
    endfunction

    // Model state and pending events for the upcoming clock edge
    bit          m_busy = 0, m_valid = 0;
    int          m_n = 0, exp_lat = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;
    bit          rst_pend = 1, acc_pend = 0, hs_pend = 0;
    logic [31:0] pa, pb;
    logic [3:0]  pc;
    bit          lit_en = 0, cur_lit = 0, p_lit = 0;
    logic [31:0] lit_res, cur_lit_res, p_lit_res;
    logic        lit_ovf, cur_lit_ovf, p_lit_ovf;
    int          lit_lat, cur_lit_lat, p_lit_lat;
    bit          drv_timeout = 0;

    // Single compare process: update model for the edge just passed, then check outputs
    always @(negedge clk) begin
        bit valid_rise;
        valid_rise = 0;
        if (rst_pend) begin
            m_busy = 0; m_valid = 0; exp_res = '0; exp_ovf = 1'b0;
        end else begin
            if (hs_pend) begin
                m_busy = 0; m_valid = 0;
            end
            if (acc_pend) begin
                m_busy = 1; m_valid = 0; m_n = 1;
                ref_alu(pa, pb, pc, exp_res, exp_ovf);
                exp_lat     = lat_of(pc);
                cur_lit     = p_lit;
                cur_lit_res = p_lit_res;
                cur_lit_ovf = p_lit_ovf;
                cur_lit_lat = p_lit_lat;
                if (cur_lit) begin
                    check("model_res_vs_literal", exp_res, cur_lit_res);
                    check("model_lat_vs_literal", 32'(exp_lat), 32'(cur_lit_lat));
                end
            end else if (m_busy && !m_valid) begin
                m_n++;
                if (m_n == exp_lat) begin
                    m_valid = 1; valid_rise = 1;
                end
            end
        end

        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (!(m_busy && !m_valid)) begin
            check("result", result, exp_res);
            check("zero", 32'(zero), 32'(exp_res == 32'd0));
            check("overflow", 32'(overflow), 32'(exp_ovf));
        end
        if (valid_rise && cur_lit) begin
            check("literal_result", result, cur_lit_res);
            check("literal_overflow", 32'(overflow), 32'(cur_lit_ovf));
        end
        check("driver_timeout", 32'(drv_timeout), 32'd0);

        rst_pend = rst;
        acc_pend = !rst && in_valid && !m_busy;
        hs_pend  = !rst && m_valid && out_ready;
        if (acc_pend) begin
            pa = src_a; pb = src_b; pc = alu_ctrl;
            p_lit = lit_en; p_lit_res = lit_res; p_lit_ovf = lit_ovf; p_lit_lat = lit_lat;
        end
    end

    // Issue one op, wait for the result, hold off out_ready for 'hold' extra cycles, then accept
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input int hold, input bit le, input logic [31:0] lr,
                         input logic lo, input int ll);
        int n;
        lit_en = le; lit_res = lr; lit_ovf = lo; lit_lat = ll;
        src_a = a; src_b = b; alu_ctrl = c; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!acc_pend && n < 50);
        if (n >= 50) drv_timeout = 1;
        // Garbage on the inputs while busy must be ignored
        n = 0;
        while (!m_valid && n < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) drv_timeout = 1;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        lit_en    = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; alu_ctrl = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_op(32'h7FFFFFFF, 32'h00000001, 4'b0010, 0, 1, 32'h80000000, 1'b1, 33);
        do_op(32'h00000005, 32'h00000005, 4'b0110, 0, 1, 32'h00000000, 1'b0, 33);
        do_op(32'h80000000, 32'h00000001, 4'b0111, 0, 1, 32'h00000001, 1'b0, 34);
        do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0111, 0, 1, 32'h00000000, 1'b0, 34);
        do_op(32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 0, 1, 32'h000F000F, 1'b0, LOGIC_LAT);
        do_op(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 0, 1, 32'hFFF0FFF0, 1'b0, LOGIC_LAT);
        // Backpressure in DONE, then a back-to-back op
        do_op(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 5, 1, 32'h00F000F0, 1'b0, LOGIC_LAT);
        do_op(32'h00000003, 32'h00000009, 4'b0110, 0, 1, 32'hFFFFFFFA, 1'b0, 33);

        // Reset in the middle of RUN
        src_a = 32'h12345678; src_b = 32'h0F0F0F0F; alu_ctrl = 4'b0010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                default: ;
            endcase
            do_op(ra, rb, 4'($urandom), $urandom_range(0, 3), 0, '0, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit ALU operation by iterating one 1-bit ALU slice LSB-first, one bit per clock.
- The slice is the standard MIPS ALU slice: Ainvert/Binvert, full adder, 4-way op mux, Set/Overflow on the MSB.
- Used as the area-minimal ALU option; the CPU issues operands over a valid/ready handshake and stalls until the result handshake completes.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- alu_ctrl  in  4  {Ainvert, Binvert, Operation[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for ADD/SUB.

Behaviour:
- Reset (sync, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, overflow=0, counter=0, carry=0. Reset mid-operation aborts; the in-flight result is discarded.
- Accept: on in_valid & in_ready, latch src_a, src_b, alu_ctrl. Later input changes are ignored. Set carry=Binvert, counter=0, clear result, go to RUN.
- RUN, per cycle, on bit i=counter:
  - ai = a[i]^Ainvert; bi = b[i]^Binvert.
  - sum = ai^bi^carry; cout = majority(ai,bi,carry).
  - Op 00 → ai&bi; 01 → ai|bi; 10 → sum; 11 → 0 (Less input; bit0 is patched in FIX).
  - Register result[i]; carry<=cout; counter++.
- MSB cycle (i=WIDTH-1):
  - ovf = carry_in^cout; set = sum^ovf, so SLT is correct under overflow.
  - Latch overflow=ovf only when Operation==10, else 0.
  - Latch set internally.
  - Next state: FIX if Operation==11, else DONE.
- FIX (one cycle): result[0]=set, other bits already 0; go to DONE.
- DONE: out_valid=1. zero is driven combinationally from result.
- Output handshake: on out_valid & out_ready, go to IDLE. in_ready rises the following cycle; no same-cycle turnaround. result/zero/overflow hold their values in IDLE until the next accept clears them.
- Latency, accept edge to first out_valid cycle: WIDTH+1 cycles (AND/OR/ADD/SUB/NOR); WIDTH+2 cycles (SLT).
- Undefined alu_ctrl codes execute per the field decoding above. No error is flagged.
- Counter wraps to 0 after WIDTH-1 and is never observed outside RUN.
- in_valid in non-IDLE states is ignored; the requester must hold it until in_ready.
- out_ready held high in DONE gives a one-cycle out_valid pulse.

Optional Feature:
- Macro BIT_SERIAL_ALU_FAST_LOGIC_EN.
- Defined: Operation 00/01 (AND, OR, NOR) bypasses RUN. The full-width logic result is computed from the latched operands in one cycle, then the block enters DONE. Latency is 2 cycles; overflow=0.
- Undefined: all ops take the serial path with the latencies above.

Test Plan:
- Reset mid-RUN: assert rst at RUN cycle 10 → next cycle state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0.
- ADD: 0x7FFFFFFF+0x00000001 → result=0x80000000, overflow=1, zero=0, out_valid exactly 33 cycles after accept.
- SUB: 0x00000005-0x00000005 → result=0, zero=1, overflow=0.
- SLT with overflow: a=0x80000000, b=0x00000001 → result=0x00000001, overflow=0, out_valid at 34 cycles. a=0x7FFFFFFF, b=0xFFFFFFFF → result=0.
- NOR/OR/AND: a=0xF0F0F0F0, b=0x0FF00FF0 → NOR=0x000F000F, OR=0xFFF0FFF0, AND=0x00F000F0. Latency is 33 cycles without the macro and 2 with BIT_SERIAL_ALU_FAST_LOGIC_EN.
- Backpressure: out_ready low 5 cycles in DONE → out_valid/result stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle, then a back-to-back op is accepted with correct result.
